// File: rtl/ex2_wb_buffer_pkg.sv
// Shared datapath types for the Ex2 -> writeback path.
// Holds the result/register types and the buffered writeback entry.
package ZionDataType;

  typedef logic [31:0] CpuType;
  typedef logic [4:0]  RegIdxType;

  typedef struct packed {
    logic      valid;
    RegIdxType rd;
    CpuType    data;
  } MultWbEntry;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_TWO   = 2'd2
  } WbBufState;

endpackage

// File: rtl/ex2_wb_entry.sv
// One buffered writeback entry: async reset, load enable, clear.
// Clear wins over load so a flush always empties the slot.
module ex2_wb_entry
  import ZionDataType::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  MultWbEntry d,
  output MultWbEntry q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex2_wb_buffer.sv
// Two-entry in-order skid buffer between Ex2 and writeback,
// with a youngest-entry bypass tap for operand forwarding.
module ex2_wb_buffer
  import ZionDataType::*;
#(
  parameter int DATA_W = $bits(CpuType),
  parameter int RD_W   = $bits(RegIdxType)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iFlush,
  input  logic              iExValid,
  input  logic [DATA_W-1:0] iExResult,
  input  logic [RD_W-1:0]   iExRd,
  output logic              oExReady,
  output logic              oWbValid,
  output logic [DATA_W-1:0] oWbData,
  output logic [RD_W-1:0]   oWbRd,
  input  logic              iWbReady,
  output logic              oBypValid,
  output logic [RD_W-1:0]   oBypRd,
  output logic [DATA_W-1:0] oBypData,
  output logic [1:0]        oCount
);

  WbBufState  state_q;
  WbBufState  state_d;
  logic       ready_q;
  MultWbEntry head_q;
  MultWbEntry skid_q;
  MultWbEntry in_e;
  MultWbEntry head_d;
  MultWbEntry young;
  logic       head_ld;
  logic       head_clr;
  logic       skid_ld;
  logic       skid_clr;
  logic       head_from_skid;
  logic       push;
  logic       pop;

  assign in_e = {1'b1, iExRd, iExResult};
  assign push = iExValid & ready_q;
  assign pop  = head_q.valid & iWbReady;

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    head_from_skid = 1'b0;
    if (iFlush) begin
      state_d  = WB_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        WB_EMPTY: begin
          if (push) begin
            state_d = WB_ONE;
            head_ld = 1'b1;
          end
        end
        WB_ONE: begin
          if (push && !pop) begin
            state_d = WB_TWO;
            skid_ld = 1'b1;
          end else if (push && pop) begin
            head_ld = 1'b1;
          end else if (pop) begin
            state_d  = WB_EMPTY;
            head_clr = 1'b1;
          end
        end
        WB_TWO: begin
          if (pop) begin
            state_d        = WB_ONE;
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = WB_EMPTY;
          head_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign head_d = head_from_skid ? skid_q : in_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != WB_TWO);
    end
  end

  ex2_wb_entry u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_ld),
    .clear (head_clr),
    .d     (head_d),
    .q     (head_q)
  );

  ex2_wb_entry u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_ld),
    .clear (skid_clr),
    .d     (in_e),
    .q     (skid_q)
  );

  // Skid always holds the younger result when occupied.
  assign young = skid_q.valid ? skid_q : head_q;

  always_comb begin
    oBypValid = young.valid & (young.rd != '0);
    oBypRd    = young.valid ? young.rd : '0;
    oBypData  = young.valid ? young.data : '0;
  end

  assign oExReady = ready_q;
  assign oWbValid = head_q.valid;
  assign oWbData  = head_q.data;
  assign oWbRd    = head_q.rd;
  assign oCount   = state_q;

endmodule

// File: tb/tb_ex2_wb_buffer.sv
// Directed self-checking bench for ex2_wb_buffer.
// Inputs change 1 time unit after each rising edge.
module tb_ex2_wb_buffer;

  logic        clk;
  logic        rst_n;
  logic        iFlush;
  logic        iExValid;
  logic [31:0] iExResult;
  logic [4:0]  iExRd;
  logic        oExReady;
  logic        oWbValid;
  logic [31:0] oWbData;
  logic [4:0]  oWbRd;
  logic        iWbReady;
  logic        oBypValid;
  logic [4:0]  oBypRd;
  logic [31:0] oBypData;
  logic [1:0]  oCount;

  int n_cmp;
  int n_bad;

  ex2_wb_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iFlush    (iFlush),
    .iExValid  (iExValid),
    .iExResult (iExResult),
    .iExRd     (iExRd),
    .oExReady  (oExReady),
    .oWbValid  (oWbValid),
    .oWbData   (oWbData),
    .oWbRd     (oWbRd),
    .iWbReady  (iWbReady),
    .oBypValid (oBypValid),
    .oBypRd    (oBypRd),
    .oBypData  (oBypData),
    .oCount    (oCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [4:0] r);
    iExValid  = v;
    iExResult = d;
    iExRd     = r;
  endtask

  task automatic test_reset();
    n_cmp++; if (oExReady !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", oExReady); end
    n_cmp++; if (oWbValid !== 1'b0) begin n_bad++; $display("FAIL rst_wbvalid got %b exp 0", oWbValid); end
    n_cmp++; if (oWbData !== 32'h0) begin n_bad++; $display("FAIL rst_wbdata got %h exp 0", oWbData); end
    n_cmp++; if (oWbRd !== 5'd0) begin n_bad++; $display("FAIL rst_wbrd got %0d exp 0", oWbRd); end
    n_cmp++; if (oBypValid !== 1'b0) begin n_bad++; $display("FAIL rst_bypvalid got %b exp 0", oBypValid); end
    n_cmp++; if (oBypData !== 32'h0) begin n_bad++; $display("FAIL rst_bypdata got %h exp 0", oBypData); end
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", oCount); end
  endtask

  task automatic test_single();
    iWbReady = 1'b1;
    drive(1'b1, 32'h0000_0006, 5'd3);
    step();
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oWbValid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b exp 1", oWbValid); end
    n_cmp++; if (oWbData !== 32'h6) begin n_bad++; $display("FAIL single_data got %h exp 6", oWbData); end
    n_cmp++; if (oWbRd !== 5'd3) begin n_bad++; $display("FAIL single_rd got %0d exp 3", oWbRd); end
    n_cmp++; if (oBypValid !== 1'b1) begin n_bad++; $display("FAIL single_byp got %b exp 1", oBypValid); end
    n_cmp++; if (oCount !== 2'd1) begin n_bad++; $display("FAIL single_count got %0d exp 1", oCount); end
    step();
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL single_drain got %0d exp 0", oCount); end
    n_cmp++; if (oWbValid !== 1'b0) begin n_bad++; $display("FAIL single_drainv got %b exp 0", oWbValid); end
  endtask

  task automatic test_backpressure();
    iWbReady = 1'b0;
    drive(1'b1, 32'h11, 5'd1);
    step();
    drive(1'b1, 32'h22, 5'd2);
    step();
    drive(1'b1, 32'h33, 5'd3);
    n_cmp++; if (oCount !== 2'd2) begin n_bad++; $display("FAIL bp_count got %0d exp 2", oCount); end
    n_cmp++; if (oExReady !== 1'b0) begin n_bad++; $display("FAIL bp_ready got %b exp 0", oExReady); end
    n_cmp++; if (oWbData !== 32'h11) begin n_bad++; $display("FAIL bp_head got %h exp 11", oWbData); end
    n_cmp++; if (oWbRd !== 5'd1) begin n_bad++; $display("FAIL bp_headrd got %0d exp 1", oWbRd); end
    n_cmp++; if (oBypData !== 32'h22) begin n_bad++; $display("FAIL bp_bypdata got %h exp 22", oBypData); end
    n_cmp++; if (oBypRd !== 5'd2) begin n_bad++; $display("FAIL bp_byprd got %0d exp 2", oBypRd); end
    step();
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oCount !== 2'd2) begin n_bad++; $display("FAIL bp_hold_count got %0d exp 2", oCount); end
    n_cmp++; if (oWbData !== 32'h11) begin n_bad++; $display("FAIL bp_hold_head got %h exp 11", oWbData); end
    n_cmp++; if (oBypData !== 32'h22) begin n_bad++; $display("FAIL bp_hold_byp got %h exp 22", oBypData); end
    iWbReady = 1'b1;
    step();
    n_cmp++; if (oWbData !== 32'h22) begin n_bad++; $display("FAIL bp_second got %h exp 22", oWbData); end
    n_cmp++; if (oWbValid !== 1'b1) begin n_bad++; $display("FAIL bp_secondv got %b exp 1", oWbValid); end
    n_cmp++; if (oCount !== 2'd1) begin n_bad++; $display("FAIL bp_one got %0d exp 1", oCount); end
    n_cmp++; if (oExReady !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back got %b exp 1", oExReady); end
    step();
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL bp_empty got %0d exp 0", oCount); end
    n_cmp++; if (oWbValid !== 1'b0) begin n_bad++; $display("FAIL bp_no33 got %b exp 0", oWbValid); end
  endtask

  task automatic test_streaming();
    iWbReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 5'd5);
      step();
      n_cmp++; if (oWbData !== 32'(i)) begin n_bad++; $display("FAIL stream_data[%0d] got %h exp %h", i, oWbData, i); end
      n_cmp++; if (oWbValid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b exp 1", i, oWbValid); end
      n_cmp++; if (oCount !== 2'd1) begin n_bad++; $display("FAIL stream_count[%0d] got %0d exp 1", i, oCount); end
    end
    drive(1'b0, 32'h0, 5'd0);
    step();
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL stream_end got %0d exp 0", oCount); end
  endtask

  task automatic test_flush();
    iWbReady = 1'b0;
    drive(1'b1, 32'hAA, 5'd4);
    step();
    drive(1'b1, 32'hBB, 5'd6);
    step();
    n_cmp++; if (oCount !== 2'd2) begin n_bad++; $display("FAIL fl_pre got %0d exp 2", oCount); end
    iFlush = 1'b1;
    drive(1'b1, 32'h44, 5'd7);
    step();
    iFlush = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL fl_count got %0d exp 0", oCount); end
    n_cmp++; if (oWbValid !== 1'b0) begin n_bad++; $display("FAIL fl_wbvalid got %b exp 0", oWbValid); end
    n_cmp++; if (oBypValid !== 1'b0) begin n_bad++; $display("FAIL fl_byp got %b exp 0", oBypValid); end
    n_cmp++; if (oBypData !== 32'h0) begin n_bad++; $display("FAIL fl_bypdata got %h exp 0", oBypData); end
    n_cmp++; if (oExReady !== 1'b1) begin n_bad++; $display("FAIL fl_ready got %b exp 1", oExReady); end
    iFlush = 1'b1;
    drive(1'b1, 32'h44, 5'd7);
    step();
    iFlush = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oWbValid !== 1'b0) begin n_bad++; $display("FAIL fl_push_drop got %b exp 0", oWbValid); end
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL fl_push_cnt got %0d exp 0", oCount); end
  endtask

  task automatic test_rd_zero();
    iWbReady = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 5'd0);
    step();
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oWbValid !== 1'b1) begin n_bad++; $display("FAIL rd0_valid got %b exp 1", oWbValid); end
    n_cmp++; if (oWbData !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rd0_data got %h exp ffffffff", oWbData); end
    n_cmp++; if (oWbRd !== 5'd0) begin n_bad++; $display("FAIL rd0_rd got %0d exp 0", oWbRd); end
    n_cmp++; if (oBypValid !== 1'b0) begin n_bad++; $display("FAIL rd0_byp got %b exp 0", oBypValid); end
    iWbReady = 1'b1;
    step();
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL rd0_drain got %0d exp 0", oCount); end
  endtask

  task automatic test_async_reset();
    iWbReady = 1'b0;
    drive(1'b1, 32'h66, 5'd8);
    step();
    drive(1'b1, 32'h77, 5'd9);
    step();
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oCount !== 2'd2) begin n_bad++; $display("FAIL ar_pre got %0d exp 2", oCount); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (oCount !== 2'd0) begin n_bad++; $display("FAIL ar_count got %0d exp 0", oCount); end
    n_cmp++; if (oExReady !== 1'b1) begin n_bad++; $display("FAIL ar_ready got %b exp 1", oExReady); end
    n_cmp++; if (oWbValid !== 1'b0) begin n_bad++; $display("FAIL ar_wbvalid got %b exp 0", oWbValid); end
    n_cmp++; if (oWbData !== 32'h0) begin n_bad++; $display("FAIL ar_wbdata got %h exp 0", oWbData); end
    n_cmp++; if (oBypValid !== 1'b0) begin n_bad++; $display("FAIL ar_byp got %b exp 0", oBypValid); end
    n_cmp++; if (oBypRd !== 5'd0) begin n_bad++; $display("FAIL ar_byprd got %0d exp 0", oBypRd); end
    #1;
    rst_n = 1'b1;
    step();
    iWbReady = 1'b1;
    drive(1'b1, 32'h55, 5'd10);
    step();
    drive(1'b0, 32'h0, 5'd0);
    n_cmp++; if (oWbData !== 32'h55) begin n_bad++; $display("FAIL ar_after_data got %h exp 55", oWbData); end
    n_cmp++; if (oCount !== 2'd1) begin n_bad++; $display("FAIL ar_after_count got %0d exp 1", oCount); end
    n_cmp++; if (oBypRd !== 5'd10) begin n_bad++; $display("FAIL ar_after_byprd got %0d exp 10", oBypRd); end
    step();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    iFlush   = 1'b0;
    iWbReady = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_single();
    test_backpressure();
    test_streaming();
    test_flush();
    test_rd_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
